// File: rtl/shift_rows_pipe_pkg.sv
// Shared AES ShiftRows definitions: per-NB row offsets, byte indexing and legal parameter ranges.
package shift_rows_pipe_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Row offsets: Rijndael uses a wider spread on rows 2/3 for 256-bit blocks.
  localparam int ROW_SHIFT_STD [4] = '{0, 1, 2, 3};
  localparam int ROW_SHIFT_NB8 [4] = '{0, 1, 3, 4};

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic int row_shift(input int nb, input int row);
    return (nb == 8) ? ROW_SHIFT_NB8[row] : ROW_SHIFT_STD[row];
  endfunction

  // Column-major state: byte k sits at row k%4, column k/4.
  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/shift_rows_stage.sv
// One valid/ready register stage; loads when empty or when its downstream accepts.
module shift_rows_stage #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  assign in_ready  = !vld_p0 || out_ready;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;

  // Stage register: flush drops the valid bit only, data keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (in_ready) begin
      vld_p0 <= in_valid;
      if (in_valid) data_p0 <= in_data;
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// AES ShiftRows/InvShiftRows with a STAGES-deep valid/ready pipeline.
// Optional per-beat bypass enabled by defining SHIFT_ROWS_PIPE_BYPASS_EN.
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  input  logic              in_bypass,
`endif
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic              busy
);

  localparam int DATA_W = 32 * NB;

  if (!nb_legal(NB) || (STAGES < STAGES_MIN) || (STAGES > STAGES_MAX)) begin : g_bad_param
    $error("shift_rows_pipe: illegal NB=%0d or STAGES=%0d", NB, STAGES);
  end

  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] inv_data;
  logic [DATA_W-1:0] perm_data;

  // Pure wiring permutation: every byte index is resolved at elaboration.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST  = DATA_W - 1 - 8 * byte_idx(r, c);
      localparam int FSRC = DATA_W - 1 - 8 * byte_idx(r, (c + row_shift(NB, r)) % NB);
      localparam int ISRC = DATA_W - 1 - 8 * byte_idx(r, (c - row_shift(NB, r) + NB) % NB);
      assign fwd_data[DST -: 8] = in_data[FSRC -: 8];
      assign inv_data[DST -: 8] = in_data[ISRC -: 8];
    end
  end

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  assign perm_data = in_bypass ? in_data : (in_inv ? inv_data : fwd_data);
`else
  assign perm_data = in_inv ? inv_data : fwd_data;
`endif

  logic [STAGES:0]   vld_c;
  logic [STAGES:0]   rdy_c;
  logic [DATA_W-1:0] data_c [STAGES+1];

  assign vld_c[0]      = in_valid;
  assign data_c[0]     = perm_data;
  assign rdy_c[STAGES] = out_ready;

  // Stage boundaries: ready ripples back from out_ready through each stage.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    shift_rows_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (vld_c[i]),
      .in_ready (rdy_c[i]),
      .in_data  (data_c[i]),
      .out_valid(vld_c[i+1]),
      .out_ready(rdy_c[i+1]),
      .out_data (data_c[i+1])
    );
  end

  assign in_ready  = rdy_c[0] && !flush && !reset;
  assign out_valid = vld_c[STAGES];
  assign out_data  = data_c[STAGES];
  assign busy      = |vld_c[STAGES:1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: known vectors, random round trips, stalled streaming, flush and reset.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         reset;
  logic [2:0]   vin, inv, ordy, fl;
  logic [255:0] din [3];
  wire  [2:0]   irdy, ov, bs;
  wire  [127:0] od0;
  wire  [191:0] od1;
  wire  [255:0] od2;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  logic [2:0]   byp;
`endif

  shift_rows_pipe #(.NB(4), .STAGES(3)) u_nb4 (
    .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(vin[0]), .in_ready(irdy[0]),
    .in_inv(inv[0]),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .in_bypass(byp[0]),
`endif
    .in_data(din[0][127:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .busy(bs[0])
  );

  shift_rows_pipe #(.NB(6), .STAGES(1)) u_nb6 (
    .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(vin[1]), .in_ready(irdy[1]),
    .in_inv(inv[1]),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .in_bypass(byp[1]),
`endif
    .in_data(din[1][191:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .busy(bs[1])
  );

  shift_rows_pipe #(.NB(8), .STAGES(2)) u_nb8 (
    .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(vin[2]), .in_ready(irdy[2]),
    .in_inv(inv[2]),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .in_bypass(byp[2]),
`endif
    .in_data(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .busy(bs[2])
  );

  function automatic int nb_of(input int u);
    return (u == 0) ? 4 : (u == 1) ? 6 : 8;
  endfunction

  function automatic int stg_of(input int u);
    return (u == 0) ? 3 : (u == 1) ? 1 : 2;
  endfunction

  function automatic logic [255:0] dout(input int u);
    case (u)
      0:       return {128'b0, od0};
      1:       return {64'b0, od1};
      default: return od2;
    endcase
  endfunction

  // Reference: pull each row out as a queue of bytes and rotate it.
  function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input bit iv);
    byte unsigned q[$];
    logic [255:0] res;
    int s;
    res = '0;
    for (int row = 0; row < 4; row++) begin
      q = {};
      for (int c = 0; c < nb; c++) q.push_back(d[nb*32-1-8*(4*c+row) -: 8]);
      s = (nb == 8 && row >= 2) ? row + 1 : row;
      for (int k = 0; k < s; k++) begin
        if (iv) q.push_front(q.pop_back());
        else    q.push_back(q.pop_front());
      end
      for (int c = 0; c < nb; c++) res[nb*32-1-8*(4*c+row) -: 8] = q[c];
    end
    return res;
  endfunction

  function automatic logic [255:0] rnd(input int nb);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    if (nb < 8) v = v & ((256'b1 << (32 * nb)) - 256'b1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: latency, value, hold under stall, then drain.
  task automatic single(input int u, input logic [255:0] d, input bit iv,
                        input logic [255:0] exp, output logic [255:0] got);
    int n;
    din[u] = d; inv[u] = iv; vin[u] = 1'b1; ordy[u] = 1'b0;
    #1;
    chk("idle_in_ready", 256'(irdy[u]), 256'(1));
    tick();
    vin[u] = 1'b0;
    n = 1;
    while (!ov[u] && n < 16) begin
      tick();
      n++;
    end
    chk("latency", 256'(n), 256'(stg_of(u)));
    got = dout(u);
    chk("perm", got, exp);
    tick();
    chk("hold_valid", 256'(ov[u]), 256'(1));
    chk("hold_data", dout(u), got);
    ordy[u] = 1'b1;
    tick();
    ordy[u] = 1'b0;
    chk("drained", 256'({ov[u], bs[u]}), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] got, fwd, back, d, held, b0;
    logic [255:0] beats [20];
    bit           ivs [20];
    logic [255:0] exp_q [$];
    int sent, rcvd, cyc, dlv;
    bit stall_prev;

    reset = 1'b1; vin = '0; inv = '0; ordy = '0; fl = '0;
    for (int u = 0; u < 3; u++) din[u] = '0;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    byp = '0;
`endif
    repeat (2) tick();
    chk("reset_in_ready", 256'(irdy), 256'(0));
    chk("reset_out_valid", 256'(ov), 256'(0));
    chk("reset_busy", 256'(bs), 256'(0));
    chk("reset_data4", dout(0), 256'(0));
    chk("reset_data8", dout(2), 256'(0));
    reset = 1'b0;
    tick();

    single(0, 256'(128'hd42711aee0bf98f1b8b45de51e415230), 1'b0,
           ref_perm(256'(128'hd42711aee0bf98f1b8b45de51e415230), 4, 1'b0), got);
    chk("kat_fwd", got, 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    single(0, 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5), 1'b1,
           ref_perm(256'(128'hd4bf5d30e0b452aeb84111f11e2798e5), 4, 1'b1), got);
    chk("kat_inv", got, 256'(128'hd42711aee0bf98f1b8b45de51e415230));
    single(0, 256'(128'h00112233445566778899aabbccddeeff), 1'b0,
           ref_perm(256'(128'h00112233445566778899aabbccddeeff), 4, 1'b0), got);
    chk("kat_seq", got, 256'(128'h0055aaff4499ee3388dd2277cc1166bb));

    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 3; k++) begin
        d = rnd(nb_of(u));
        single(u, d, 1'b0, ref_perm(d, nb_of(u), 1'b0), fwd);
        single(u, fwd, 1'b1, ref_perm(fwd, nb_of(u), 1'b1), back);
        chk("roundtrip", back, d);
      end
    end

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    byp[0] = 1'b1;
    single(0, 256'(128'h00112233445566778899aabbccddeeff), 1'b0,
           256'(128'h00112233445566778899aabbccddeeff), got);
    single(0, 256'(128'h00112233445566778899aabbccddeeff), 1'b1,
           256'(128'h00112233445566778899aabbccddeeff), got);
    byp[0] = 1'b0;
`endif

    // Streaming with random backpressure on the 3-stage instance.
    for (int i = 0; i < 20; i++) begin
      beats[i] = rnd(4);
      ivs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (rcvd < 20 && cyc < 400) begin
      vin[0] = (sent < 20);
      if (sent < 20) begin
        din[0] = beats[sent];
        inv[0] = ivs[sent];
      end
      ordy[0] = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        chk("stall_valid", 256'(ov[0]), 256'(1));
        chk("stall_data", dout(0), held);
      end
      chk("stream_in_ready", 256'(irdy[0]), 256'(!((sent - rcvd) == 3 && !ordy[0])));
      if (ov[0] && ordy[0]) begin
        if (exp_q.size() > 0) chk("stream_order", dout(0), exp_q.pop_front());
        else chk("stream_spurious", 256'(ov[0]), 256'(0));
        rcvd++;
      end
      if (vin[0] && irdy[0]) begin
        exp_q.push_back(ref_perm(beats[sent], 4, ivs[sent]));
        sent++;
      end
      stall_prev = ov[0] && !ordy[0];
      held = dout(0);
      tick();
      cyc++;
    end
    vin[0] = 1'b0; ordy[0] = 1'b0;
    chk("stream_count", 256'(rcvd), 256'(20));

    // Flush with both stages full and a beat offered in the same cycle.
    ordy[2] = 1'b0; inv[2] = 1'b0; vin[2] = 1'b1;
    b0 = rnd(8);
    din[2] = b0;
    tick();
    din[2] = rnd(8);
    tick();
    chk("full_not_ready", 256'(irdy[2]), 256'(0));
    fl[2] = 1'b1;
    din[2] = rnd(8);
    #1;
    chk("flush_in_ready", 256'(irdy[2]), 256'(0));
    tick();
    fl[2] = 1'b0; vin[2] = 1'b0;
    chk("flush_busy", 256'(bs[2]), 256'(0));
    chk("flush_out_valid", 256'(ov[2]), 256'(0));
    chk("flush_data_kept", dout(2), ref_perm(b0, 8, 1'b0));
    ordy[2] = 1'b1; dlv = 0;
    for (int k = 0; k < 4; k++) begin
      if (ov[2]) dlv++;
      tick();
    end
    ordy[2] = 1'b0;
    chk("flush_no_beat", 256'(dlv), 256'(0));

    // Reset mid-stream on the same full pipeline.
    vin[2] = 1'b1;
    din[2] = rnd(8);
    tick();
    din[2] = rnd(8);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 256'(irdy[2]), 256'(0));
    tick();
    reset = 1'b0; vin[2] = 1'b0;
    chk("rst_busy", 256'(bs[2]), 256'(0));
    chk("rst_out_valid", 256'(ov[2]), 256'(0));
    chk("rst_out_data", dout(2), 256'(0));
    ordy[2] = 1'b1; dlv = 0;
    for (int k = 0; k < 4; k++) begin
      if (ov[2]) dlv++;
      tick();
    end
    ordy[2] = 1'b0;
    chk("rst_no_beat", 256'(dlv), 256'(0));
    d = rnd(8);
    single(2, d, 1'b1, ref_perm(d, 8, 1'b1), got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns (legal 4, 6, 8); DATA_W = 32*NB.
REQ-002 The block SHALL have parameter STAGES, default 1, meaning pipeline register stages (legal 1..4).
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port flush  input  1  meaning synchronous pipeline clear.
REQ-006 The block SHALL have port in_valid  input  1  meaning input beat valid.
REQ-007 The block SHALL have port in_ready  output  1  meaning block accepts a beat this cycle.
REQ-008 The block SHALL have port in_inv  input  1  meaning 0 = ShiftRows, 1 = InvShiftRows, sampled per beat.
REQ-009 The block SHALL have port in_data  input  DATA_W  meaning input state.
REQ-010 The block SHALL have port out_valid  output  1  meaning output beat valid.
REQ-011 The block SHALL have port out_ready  input  1  meaning downstream accepts.
REQ-012 The block SHALL have port out_data  output  DATA_W  meaning permuted state.
REQ-013 The block SHALL have port busy  output  1  meaning high when any stage holds a valid beat.

Function
REQ-014 Byte mapping SHALL be byte k = in_data[DATA_W-1-8k -: 8], row r = k mod 4, column c = k div 4; out_data uses the same mapping.
REQ-015 Row offsets SHALL be s = {0,1,2,3} for NB 4/6 and s = {0,1,3,4} for NB 8.
REQ-016 Forward mode SHALL give out[r][c] = in[r][(c+s[r]) mod NB].
REQ-017 Inverse mode SHALL give out[r][c] = in[r][(c-s[r]+NB) mod NB].
REQ-018 The permutation SHALL be applied combinationally before stage 0; stages 1..STAGES-1 carry data unchanged.
REQ-019 A transfer SHALL occur on valid&&ready at each boundary, with no beat dropped or duplicated.
REQ-020 Stage i SHALL load when it is empty or stage i+1 (or the output for the last stage) advances; otherwise it holds.
REQ-021 in_ready SHALL equal stage-0-can-load && !flush && !reset.
REQ-022 out_valid and out_data SHALL be the last stage registers and remain stable while out_valid && !out_ready.
REQ-023 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when unstalled.
REQ-024 Throughput SHALL be one beat per cycle under continuous out_ready, including simultaneous accept and drain with all stages full.
REQ-025 flush SHALL clear all stage valid bits at the next edge, override a simultaneous accept, and leave data registers unchanged.
REQ-026 Beats SHALL leave in acceptance order, each with its own sampled in_inv.

Reset
REQ-027 reset SHALL have priority over flush and all transfers.
REQ-028 Reset SHALL clear all stage valid bits and data to 0, so out_valid=0, out_data=0, busy=0, and in_ready=0 while reset is high.
REQ-029 Asserting reset mid-stream SHALL discard all in-flight beats, with the first legal accept on the cycle after reset deasserts.

Configuration
REQ-030 Macro SHIFT_ROWS_PIPE_BYPASS_EN SHALL govern bypass support.
REQ-031 With SHIFT_ROWS_PIPE_BYPASS_EN defined, input port in_bypass (1 bit) SHALL exist, and a beat accepted with in_bypass=1 SHALL pass in_data unpermuted, ignoring in_inv, with identical latency and handshake.
REQ-032 Without SHIFT_ROWS_PIPE_BYPASS_EN, the in_bypass port and its logic SHALL be absent and every beat SHALL be permuted.

Structure
REQ-033 The shared AES package SHALL hold the row-offset table per NB, the byte-index helper function, and legal-parameter constants.
REQ-034 One sub-module, shift_rows_stage, SHALL implement a single valid/ready register stage and be instantiated STAGES times via generate.
REQ-035 Illegal NB or STAGES SHALL cause an elaboration error.

Verification
REQ-036 With NB=4, forward, in_data=d42711aee0bf98f1b8b45de51e415230, the bench SHALL see out_data=d4bf5d30e0b452aeb84111f11e2798e5 after STAGES cycles.
REQ-037 With NB=4, inverse, in_data=d4bf5d30e0b452aeb84111f11e2798e5, the bench SHALL see out_data=d42711aee0bf98f1b8b45de51e415230.
REQ-038 With NB=4, forward, in_data=00112233445566778899aabbccddeeff, the bench SHALL see 0055aaff4499ee3388dd2277cc1166bb; for NB=6/8, random round-trip forward->inverse SHALL equal the input.
REQ-039 With STAGES=3, 20 back-to-back beats, and random out_ready (50%), all 20 beats SHALL emerge in order, out_data stable during stalls, and in_ready low only when full and stalled.
REQ-040 With STAGES=2 full, asserting flush one cycle with in_valid=1 SHALL leave busy=0 and out_valid=0 next cycle with no beat delivered; reset asserted mid-stream SHALL behave identically.
REQ-041 With the macro defined and in_bypass=1, in_data=00112233445566778899aabbccddeeff SHALL produce out_data=00112233445566778899aabbccddeeff.
